cdb_result_table: RTL

- Per-ROB-tag result store that sits directly downstream of the reservation stations and their ALUs.
- Captures every functional-unit result (ALU, JAL/JALR/AUIPC pc-link values, branch outcomes) indexed by its rd tag.
- Presents the registered per-tag results as the cdb array, and the allocated_rob_entries / robs_calculated vectors, that all reservation stations and the ROB snoop.
- Also tracks per-tag lifecycle (free, allocated, calculated), so flushes and commits clear stale data deterministically.

---
 rtl/cdb_result_table.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cdb_result_table.sv
// Shared result-bus types snooped by the reservation stations and the ROB.
package tomasula_types;

    localparam int unsigned CdbDataW = 32;

    // One broadcast slot per ROB tag; .data holds the registered result.
    typedef struct packed {
        logic [CdbDataW-1:0] data;
    } cdb_data;

endpackage

// cdb_result_table: per-ROB-tag result store fed by the functional units.
// Each tag runs a small FREE/ALLOC/CALC lifecycle so that flushes and commits
// leave no stale results behind. Every output is taken straight from flops,
// so a result written in cycle N is visible in cycle N+1 (no bypass).
module cdb_result_table #(
    parameter int unsigned NUM_TAGS = 8,
    parameter int unsigned TAG_W    = 3,
    parameter int unsigned NUM_FU   = 3,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      alloc_valid,
    input  logic [TAG_W-1:0]                          alloc_tag,
    input  logic [NUM_FU-1:0]                         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]                   fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]                  fu_data,
    input  logic [NUM_FU-1:0]                         fu_br,
    input  logic                                      commit_valid,
    input  logic [TAG_W-1:0]                          commit_tag,
    output tomasula_types::cdb_data [NUM_TAGS-1:0]    cdb,
    output logic [NUM_TAGS-1:0]                       robs_calculated,
    output logic [NUM_TAGS-1:0]                       allocated_rob_entries,
    output logic [NUM_TAGS-1:0]                       br_result,
    output logic                                      write_conflict,
    output logic                                      stray_write
);

    typedef enum logic [1:0] {
        StFree  = 2'd0,
        StAlloc = 2'd1,
        StCalc  = 2'd2
    } entry_state_e;

    // Registered per-entry state.
    entry_state_e              state_q [NUM_TAGS];
    entry_state_e              state_d [NUM_TAGS];
    logic [DATA_W-1:0]         data_q  [NUM_TAGS];
    logic [DATA_W-1:0]         data_d  [NUM_TAGS];
    logic [NUM_TAGS-1:0]       br_q;
    logic [NUM_TAGS-1:0]       br_d;

    // Registered diagnostic pulses.
    logic                      write_conflict_q;
    logic                      write_conflict_d;
    logic                      stray_write_q;
    logic                      stray_write_d;

    // Per-tag winning write after port arbitration.
    logic [NUM_TAGS-1:0]       wr_hit;
    logic [DATA_W-1:0]         wr_data [NUM_TAGS];
    logic [NUM_TAGS-1:0]       wr_br;
    logic                      same_tag_writes;

    // Port arbitration: scan from the highest port down so the lowest-index
    // port targeting a tag is the one left standing.
    always_comb begin
        for (int t = 0; t < NUM_TAGS; t++) begin
            wr_hit[t]  = 1'b0;
            wr_data[t] = '0;
            wr_br[t]   = 1'b0;
            for (int i = int'(NUM_FU) - 1; i >= 0; i--) begin
                if (fu_valid[i] && (fu_tag[i*TAG_W +: TAG_W] == TAG_W'(t))) begin
                    wr_hit[t]  = 1'b1;
                    wr_data[t] = fu_data[i*DATA_W +: DATA_W];
                    wr_br[t]   = fu_br[i];
                end
            end
        end
    end

    // Detect any pair of valid ports aimed at the same tag this cycle.
    always_comb begin
        same_tag_writes = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = i + 1; j < NUM_FU; j++) begin
                if (fu_valid[i] && fu_valid[j] &&
                    (fu_tag[i*TAG_W +: TAG_W] == fu_tag[j*TAG_W +: TAG_W])) begin
                    same_tag_writes = 1'b1;
                end
            end
        end
    end

    // Per-entry next state: flush > commit > alloc > write.
    always_comb begin
        state_d          = state_q;
        data_d           = data_q;
        br_d             = br_q;
        stray_write_d    = 1'b0;
        // A flush discards everything else presented in the same cycle.
        write_conflict_d = same_tag_writes && !flush;

        for (int t = 0; t < NUM_TAGS; t++) begin
            if (flush) begin
                state_d[t] = StFree;
                data_d[t]  = '0;
                br_d[t]    = 1'b0;
            end else if (commit_valid && (commit_tag == TAG_W'(t))) begin
                // Retirement wins over a late result for the same tag.
                state_d[t] = StFree;
                data_d[t]  = '0;
                br_d[t]    = 1'b0;
            end else if (alloc_valid && (alloc_tag == TAG_W'(t))) begin
                if (state_q[t] == StFree) begin
                    state_d[t] = StAlloc;
                    data_d[t]  = '0;
                    br_d[t]    = 1'b0;
                    // The entry was free when the write was issued.
                    if (wr_hit[t]) begin
                        stray_write_d = 1'b1;
                    end
                end
                // Re-allocating a live tag is a ROB bug; leave the entry alone.
            end else if (wr_hit[t]) begin
                if (state_q[t] == StFree) begin
                    // Result for a flushed or committed entry: drop it.
                    stray_write_d = 1'b1;
                end else begin
                    state_d[t] = StCalc;
                    data_d[t]  = wr_data[t];
                    br_d[t]    = wr_br[t];
                end
            end
        end
    end

    // State, data and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                state_q[t] <= StFree;
                data_q[t]  <= '0;
            end
            br_q             <= '0;
            write_conflict_q <= 1'b0;
            stray_write_q    <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                state_q[t] <= state_d[t];
                data_q[t]  <= data_d[t];
            end
            br_q             <= br_d;
            write_conflict_q <= write_conflict_d;
            stray_write_q    <= stray_write_d;
        end
    end

    // Output vectors decoded purely from registered state.
    always_comb begin
        for (int t = 0; t < NUM_TAGS; t++) begin
            cdb[t].data              = data_q[t];
            allocated_rob_entries[t] = (state_q[t] != StFree);
            robs_calculated[t]       = (state_q[t] == StCalc);
        end
        br_result      = br_q;
        write_conflict = write_conflict_q;
        stray_write    = stray_write_q;
    end

endmodule
